mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single-ported 16-bit word-addressed main memory. It shares that memory between the instruction-fetch port (read-only) and the data port (load/store). It registers the chosen request onto the memory address/write lines, holds them for a configurable number of cycles, captures read data, and returns a one-cycle acknowledge. The block sits between the CPU front end / load-store unit and the memory.

## Interface
- `ADDR_W`, default 16: address width; matches the memory's 64K-word space.
- `DATA_W`, default 16: word width.
- `WAIT_CYCLES`, default 1: cycles the memory lines are held per access; legal range 1..15.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle pulse; the fetch has completed.
- `if_rdata` out DATA_W: fetched word; valid while `if_ack` is high, held afterwards.
- `d_req` in 1: data request.
- `d_we` in 1: 1 means store, 0 means load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out DATA_W: load result; updated only by load acks.
- `mem_write` out 1: drives the memory `write` input.
- `mem_address` out ADDR_W: drives the memory `address` input.
- `mem_writeData` out DATA_W: drives the memory `writeData` input.
- `mem_data` in DATA_W: memory read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- State machine with three states: IDLE, ACCESS, ACK.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner, latch its address, write-data and we, and set the owner register; go to ACCESS with the wait counter at 0.
- **ACCESS**
  - `mem_address` and `mem_writeData` carry the latched values.
  - `mem_write` equals the latched we (always 0 for fetch).
  - The counter increments each cycle. On the edge where counter == WAIT_CYCLES-1:
    - for a load or fetch, capture `mem_data` into the owner's rdata register;
    - go to ACK.
- **ACK**
  - `mem_write` = 0. `mem_address` and `mem_writeData` are still held.
  - The owner's ack is high for exactly this one cycle.
  - Next state is IDLE unconditionally. Requests are not sampled in ACK.
- **Requester contract**
  - Hold req, addr, we and wdata stable from req assertion until ack is seen.
  - Deassert req in the ack cycle. A req still high in the cycle after ack is treated as a new transaction.
- **Arbitration** applies only when both req are high in IDLE (see Configuration).
- **Losing port:** its req stays pending and is served next. No request is dropped.
- **Reset outputs:** state IDLE; every output 0, including both rdata registers. The round-robin pointer resets to favour fetch.

## Timing
- Latency from the req-sampling edge in IDLE to ack high: WAIT_CYCLES+1 edges.
- Ack lasts 1 cycle.
- Throughput: one transaction per WAIT_CYCLES+2 cycles under continuous load.
- With WAIT_CYCLES=1: req sampled at edge 0; ACCESS in cycle 0→1 with `mem_write` high for stores; rdata captured at edge 1; ack during cycle 1→2; IDLE at edge 2; next req sampled at edge 3.
- Stores: `mem_write` is high for exactly WAIT_CYCLES cycles and never high outside ACCESS.
- `mem_address` changes only on entry to ACCESS.
- Reset asserted in ACCESS or ACK:
  - next state IDLE;
  - `mem_write` 0 after that edge;
  - no ack is issued for the aborted transaction.
- Address wrap-around: none. Addresses pass through unchanged; 16'hFFFF is a legal address.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On conflict, the port not granted most recently wins. The pointer updates on every grant, including uncontested ones.
- `MEM_ARB_RR_EN` undefined: fixed priority; the data port always wins. A continuous `d_req` may starve fetch. This is the intended behaviour, because the load-store unit holds the pipeline.

## Structure
- Package `mem_arb_pkg` holds:
  - the state typedef (IDLE, ACCESS, ACK);
  - port-index constants PORT_IF=0, PORT_D=1;
  - the wait-counter width constant (4 bits).
- Sub-module `mem_arb_pick`: a combinational winner select. Inputs are both reqs and the last-grant bit; output is the winner index. It contains the only `MEM_ARB_RR_EN`-dependent logic.

## Test plan
- Single fetch, WAIT_CYCLES=1, memory word 0x00FF at 0xFFFF: `if_req`, `if_addr`=0xFFFF → `if_ack` 2 edges later, `if_rdata`=0x00FF, `mem_write` never high.
- Store then load: store 0xBEEF to 0x0010, then load 0x0010 → `mem_write` high 1 cycle with `mem_address`=0x0010; load returns `d_rdata`=0xBEEF; `d_rdata` unchanged by the store ack.
- Simultaneous requests held continuously for 4 transactions:
  - without the macro, all 4 acks go to data;
  - with `MEM_ARB_RR_EN`, acks alternate data/fetch starting with fetch after reset.
- WAIT_CYCLES=3 store: `mem_write` high exactly 3 cycles; `d_ack` 4 edges after sampling; next grant no earlier than 5 edges after sampling.
- Reset asserted during ACCESS of a store to 0x0020 → IDLE next edge, `mem_write`=0, no `d_ack`, all outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state type, port indices and counter width for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// MEM_ARB_RR_EN defined: round-robin on conflict; undefined: data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = PORT_IF;
    if (if_req && d_req) begin
      winner = ~last_grant;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end
`else
  // Fixed priority ignores the fetch request and the grant history.
  logic unused_pick;
  assign unused_pick = if_req ^ last_grant;

  always_comb begin
    winner = d_req ? PORT_D : PORT_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported main memory (fetch + load/store).
// Arbitration policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              last_grant;
  logic              winner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nx = ACCESS;
      ACCESS:  if (cnt == CNT_LAST) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_write = (state == ACCESS) && lat_we;
    if_ack    = (state == ACK) && (owner == PORT_IF);
    d_ack     = (state == ACK) && (owner == PORT_D);
    busy      = (state != IDLE);
  end

  assign mem_address   = lat_addr;
  assign mem_writeData = lat_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= PORT_IF;
      last_grant <= PORT_D;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner      <= winner;
            last_grant <= winner;
            cnt        <= '0;
            if (winner == PORT_D) begin
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
              lat_we    <= d_we;
            end else begin
              // Fetch keeps the previous write data on the bus; it is never written.
              lat_addr <= if_addr;
              lat_we   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if ((cnt == CNT_LAST) && !lat_we) begin
            if (owner == PORT_D) d_rdata <= mem_data;
            else                 if_rdata <= mem_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases plus randomized two-port traffic
// against a word-level memory reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned WC    = 1;
  localparam int unsigned WC3   = 3;
  localparam int unsigned LIMIT = 200;
  localparam int unsigned NRAND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with WAIT_CYCLES=1
  logic        reset, if_req, if_ack, d_req, d_we, d_ack, mem_write, busy;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [15:0] mem_address, mem_writeData, mem_data;

  // DUT with WAIT_CYCLES=3
  logic        reset3, if_req3, if_ack3, d_req3, d_we3, d_ack3, mem_write3, busy3;
  logic [15:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3;
  logic [15:0] mem_address3, mem_writeData3, mem_data3;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_write(mem_write), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_data(mem_data), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WC3)) dut3 (
    .clk(clk), .reset(reset3),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_write(mem_write3), .mem_address(mem_address3), .mem_writeData(mem_writeData3),
    .mem_data(mem_data3), .busy(busy3)
  );

  // Behavioural single-ported memories seen by the DUTs
  logic [15:0] mem  [0:65535];
  logic [15:0] mem3 [0:65535];
  assign mem_data  = mem[mem_address];
  assign mem_data3 = mem3[mem_address3];
  always @(posedge clk) if (mem_write)  mem[mem_address]   <= mem_writeData;
  always @(posedge clk) if (mem_write3) mem3[mem_address3] <= mem_writeData3;

  // Reference model: architectural memory contents and last load result
  logic [15:0] ref_mem [0:65535];
  logic [15:0] d_last_load;

  function automatic logic [15:0] init_word(input int unsigned a);
    return 16'(a) ^ 16'hFF00;
  endfunction

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard queues and monitor
  logic [15:0] if_exp_q[$];
  logic [15:0] d_exp_q[$];
  logic        ack_log[$];
  logic [15:0] mon_exp;
  int unsigned mw_cnt = 0;
  int unsigned mw3_cnt = 0;
  logic [15:0] mw_addr = '0;

  always @(negedge clk) begin
    if (if_ack && d_ack) flag("both_acks_high");
    if (if_ack) begin
      ack_log.push_back(1'b0);
      if (if_exp_q.size() == 0) flag("if_ack_unexpected");
      else begin
        mon_exp = if_exp_q.pop_front();
        chk("if_rdata", {16'h0, if_rdata}, {16'h0, mon_exp});
      end
    end
    if (d_ack) begin
      ack_log.push_back(1'b1);
      if (d_exp_q.size() == 0) flag("d_ack_unexpected");
      else begin
        mon_exp = d_exp_q.pop_front();
        chk("d_rdata", {16'h0, d_rdata}, {16'h0, mon_exp});
      end
    end
    if (mem_write) begin
      mw_cnt++;
      mw_addr = mem_address;
      chk("mem_write_only_in_access", {30'h0, busy, if_ack | d_ack}, 32'h2);
    end
    if (mem_write3) begin
      mw3_cnt++;
      chk("wc3_mem_write_only_in_access", {30'h0, busy3, if_ack3 | d_ack3}, 32'h2);
    end
  end

  task automatic do_fetch(input logic [15:0] a, output int unsigned lat);
    int unsigned s;
    bit got;
    got = 1'b0;
    if_addr = a;
    if_req = 1'b1;
    if_exp_q.push_back(ref_mem[a]);
    s = cyc + 1;
    for (int i = 0; i < LIMIT && !got; i++) begin
      @(negedge clk);
      got = if_ack;
    end
    if_req = 1'b0;
    if (!got) begin
      flag("if_ack_timeout");
      lat = 0;
    end else lat = cyc - s + 1;
  endtask

  task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         output int unsigned lat);
    int unsigned s;
    bit got;
    got = 1'b0;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    if (we) begin
      ref_mem[a] = wd;
      d_exp_q.push_back(d_last_load);
    end else begin
      d_last_load = ref_mem[a];
      d_exp_q.push_back(ref_mem[a]);
    end
    s = cyc + 1;
    for (int i = 0; i < LIMIT && !got; i++) begin
      @(negedge clk);
      got = d_ack;
    end
    d_req = 1'b0;
    if (!got) begin
      flag("d_ack_timeout");
      lat = 0;
    end else lat = cyc - s + 1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d_last_load = '0;
  endtask

  initial begin
    #1_000_000;
    flag("watchdog_expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int unsigned lat, mw0, s, t1, t2, n_ack;
    bit got;
    logic exp_owner [5];
    logic last, p_if, p_d, w;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
      mem3[i]    = '0;
    end
    {if_req, d_req, d_we, if_req3, d_req3, d_we3} = '0;
    {if_addr, d_addr, d_wdata, if_addr3, d_addr3, d_wdata3} = '0;
    d_last_load = '0;
    reset = 1'b1;
    reset3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {28'h0, if_ack, d_ack, mem_write, busy}, 32'h0);
    chk("reset_rdata", {if_rdata, d_rdata}, 32'h0);
    chk("reset_mem_bus", {mem_address, mem_writeData}, 32'h0);
    chk("wc3_reset_outputs", {if_rdata3, d_rdata3} | {28'h0, if_ack3, d_ack3, mem_write3, busy3}, 32'h0);
    reset = 1'b0;
    reset3 = 1'b0;
    @(negedge clk);

    // Single fetch of the top word; latency counts the sampling edge
    mw0 = mw_cnt;
    do_fetch(16'hFFFF, lat);
    chk("fetch_ffff_latency", lat, WC + 1);
    chk("fetch_ffff_rdata", {16'h0, if_rdata}, 32'h00FF);
    chk("fetch_no_mem_write", mw_cnt - mw0, 0);
    @(negedge clk);

    // Store then load at 0x0010
    mw0 = mw_cnt;
    do_data(1'b1, 16'h0010, 16'hBEEF, lat);
    chk("store_latency", lat, WC + 1);
    chk("store_write_cycles", mw_cnt - mw0, WC);
    chk("store_write_addr", {16'h0, mw_addr}, 32'h0010);
    chk("store_leaves_d_rdata", {16'h0, d_rdata}, 32'h0);
    @(negedge clk);
    do_data(1'b0, 16'h0010, 16'h0000, lat);
    chk("load_latency", lat, WC + 1);
    chk("load_rdata", {16'h0, d_rdata}, 32'hBEEF);
    chk("load_bus_held", {16'h0, mem_address}, 32'h0010);

    // Both ports requesting continuously from reset: four contested grants, then drain
    pulse_reset();
    last = 1'b1;
    p_if = 1'b1;
    p_d  = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef MEM_ARB_RR_EN
      w = (p_if && p_d) ? ~last : p_d;
`else
      w = p_d;
`endif
      exp_owner[k] = w;
      last = w;
      if (k >= 3) begin
        if (w) p_d = 1'b0;
        else   p_if = 1'b0;
      end
    end
    ack_log.delete();
    if_addr = 16'h9000;
    if_req = 1'b1;
    if_exp_q.push_back(ref_mem[16'h9000]);
    d_we = 1'b0;
    d_addr = 16'h0011;
    d_req = 1'b1;
    d_last_load = ref_mem[16'h0011];
    d_exp_q.push_back(ref_mem[16'h0011]);
    n_ack = 0;
    for (int i = 0; i < LIMIT && n_ack < 5; i++) begin
      @(negedge clk);
      if (if_ack) begin
        n_ack++;
        if (n_ack < 4) if_exp_q.push_back(ref_mem[16'h9000]);
        else if_req = 1'b0;
      end
      if (d_ack) begin
        n_ack++;
        if (n_ack < 4) d_exp_q.push_back(ref_mem[16'h0011]);
        else d_req = 1'b0;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("contend_ack_count", ack_log.size(), 5);
    for (int k = 0; k < 5 && k < ack_log.size(); k++)
      chk($sformatf("contend_owner_%0d", k), {31'h0, ack_log[k]}, {31'h0, exp_owner[k]});

    // Reset during ACCESS of a store: aborted, no ack
    d_we = 1'b1;
    d_addr = 16'h0020;
    d_wdata = ref_mem[16'h0020];
    d_req = 1'b1;
    @(negedge clk);
    chk("abort_in_access", {30'h0, busy, mem_write}, 32'h3);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    chk("abort_ctrl_zero", {28'h0, if_ack, d_ack, mem_write, busy}, 32'h0);
    chk("abort_rdata_zero", {if_rdata, d_rdata}, 32'h0);
    chk("abort_bus_zero", {mem_address, mem_writeData}, 32'h0);
    reset = 1'b0;
    d_last_load = '0;
    n_ack = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_ack || busy) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);

    // Randomized traffic on both ports
    fork
      begin
        int unsigned flat;
        for (int k = 0; k < NRAND; k++) begin
          do_fetch(16'($urandom_range(65535, 32768)), flat);
          chk("rand_fetch_lat_min", {31'h0, flat >= WC + 1}, 32'h1);
`ifdef MEM_ARB_RR_EN
          chk("rand_fetch_lat_max", {31'h0, flat <= 2 * WC + 4}, 32'h1);
`endif
          repeat ($urandom_range(4, 0)) @(negedge clk);
        end
      end
      begin
        int unsigned dlat;
        for (int k = 0; k < NRAND; k++) begin
          do_data(1'($urandom_range(1, 0)), 16'($urandom_range(255, 0)),
                  16'($urandom), dlat);
          chk("rand_data_lat_range",
              {31'h0, (dlat >= WC + 1) && (dlat <= 2 * WC + 4)}, 32'h1);
          repeat ($urandom_range(4, 0)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("if_queue_drained", if_exp_q.size(), 0);
    chk("d_queue_drained", d_exp_q.size(), 0);

    // WAIT_CYCLES=3: store, then a back-to-back load held on the same request
    mw0 = mw3_cnt;
    d_we3 = 1'b1;
    d_addr3 = 16'h0005;
    d_wdata3 = 16'h1357;
    d_req3 = 1'b1;
    s = cyc + 1;
    got = 1'b0;
    for (int i = 0; i < LIMIT && !got; i++) begin
      @(negedge clk);
      got = d_ack3;
    end
    if (!got) flag("wc3_store_ack_timeout");
    t1 = cyc;
    chk("wc3_store_ack_latency", t1 - s + 1, WC3 + 1);
    chk("wc3_store_leaves_d_rdata", {16'h0, d_rdata3}, 32'h0);
    d_we3 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < LIMIT && !got; i++) begin
      @(negedge clk);
      got = d_ack3;
    end
    if (!got) flag("wc3_load_ack_timeout");
    t2 = cyc;
    d_req3 = 1'b0;
    chk("wc3_next_grant_spacing", t2 - t1, WC3 + 2);
    chk("wc3_write_cycles", mw3_cnt - mw0, WC3);
    chk("wc3_load_rdata", {16'h0, d_rdata3}, 32'h1357);
    chk("wc3_if_rdata_untouched", {16'h0, if_rdata3}, 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
